// File: rtl/spi_fifo_tx_ctrl.sv
// spi_fifo_tx_ctrl: pops FIFO words and serialises each as a CS-framed SPI mode-0 MSB-first transfer
module spi_fifo_tx_ctrl #(
  parameter int DATA_W   = 24,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 4,
  parameter int GAP      = 4
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  output logic              busy,
  output logic              frame_done
);
  localparam int MAX_A = CLK_DIV > CS_SETUP ? CLK_DIV : CS_SETUP;
  localparam int MAX_B = CS_HOLD > GAP ? CS_HOLD : GAP;
  localparam int MAX_C = MAX_A > MAX_B ? MAX_A : MAX_B;
  localparam int MAX_V = MAX_C > DATA_W ? MAX_C : DATA_W;
  localparam int CW = $clog2(MAX_V + 1);
  localparam logic [CW-1:0] DIV_L = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SET_L = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HLD_L = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_L = CW'(GAP - 1);
  localparam logic [CW-1:0] BIT_L = CW'(DATA_W - 1);
  typedef enum logic [2:0] {S_IDLE, S_POP, S_LOAD, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic cs_n_q, cs_n_d, sclk_q, sclk_d, mosi_q, mosi_d, rd_en_q, rd_en_d, busy_q, done_q, done_d;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      rd_en_q <= rd_en_d;
      busy_q  <= state_d != S_IDLE;
      done_q  <= done_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    rd_en_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        rd_en_d = enable && !fifo_empty;
        state_d = rd_en_d ? S_POP : S_IDLE;
      end
      S_POP: begin
        cs_n_d  = 1'b0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        shreg_d = fifo_rd_data;
        mosi_d  = fifo_rd_data[DATA_W-1];
        cnt_d   = '0;
        state_d = S_SETUP;
      end
      S_SETUP: begin
        cnt_d   = cnt_q == SET_L ? '0 : cnt_q + 1'b1;
        bit_d   = '0;
        state_d = cnt_q == SET_L ? S_SHIFT : S_SETUP;
      end
      S_SHIFT: begin
        cnt_d = cnt_q == DIV_L ? '0 : cnt_q + 1'b1;
        if (cnt_q == DIV_L) begin
          sclk_d = !sclk_q;
          if (sclk_q && bit_q == BIT_L)
            state_d = S_HOLD;
          else if (sclk_q) begin
            shreg_d = shreg_q << 1;
            mosi_d  = shreg_q[DATA_W-2];
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      S_HOLD: begin
        cnt_d = cnt_q == HLD_L ? '0 : cnt_q + 1'b1;
        if (cnt_q == HLD_L) begin
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          mosi_d  = 1'b0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        cnt_d   = cnt_q == GAP_L ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == GAP_L ? S_IDLE : S_GAP;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign fifo_rd_en = rd_en_q;
  assign spi_cs_n   = cs_n_q;
  assign spi_sclk   = sclk_q;
  assign spi_mosi   = mosi_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_spi_fifo_tx_ctrl.sv
// tb_spi_fifo_tx_ctrl: randomized self-checking bench against a queue-based SPI frame model
module tb_spi_fifo_tx_ctrl;
  localparam int DATA_W = 24, CLK_DIV = 4, CS_SETUP = 2, CS_HOLD = 4, GAP = 4;
  localparam int LOW_T = 1 + CS_SETUP + 2 * CLK_DIV * DATA_W + CS_HOLD;
  localparam int LOW_F = 1 + 1 + 2 * 1 * DATA_W + 1;
  logic HCLK = 0, HRESETn = 0, enable = 0, fifo_empty = 1;
  logic fifo_rd_en, spi_cs_n, spi_sclk, spi_mosi, busy, frame_done;
  logic [DATA_W-1:0] fifo_rd_data = '0;
  logic en_f = 0, empty_f = 1, go_f = 0;
  logic rd_f, cs_f, sclk_f, mosi_f, busy_f, done_f;
  logic [DATA_W-1:0] rd_data_f = '0;
  logic [DATA_W-1:0] fifo_q[$], exp_q[$];
  logic [DATA_W-1:0] word = '0, last_word = '0, word_f = '0;
  int n_vec = 0, n_err = 0;
  int nbits = 0, low = 0, high = 0, frames = 0, rd_cnt = 0;
  int nb_f = 0, low_f = 0, frames_f = 0, rd_cnt_f = 0, cyc = 0, last_rise = 0;
  logic seen = 0, prev_cs = 1, prev_sclk = 0, prev_rd = 0, prev_cs_f = 1, prev_sclk_f = 0;
  always #5 HCLK = ~HCLK;
  spi_fifo_tx_ctrl #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .GAP(GAP)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .enable(enable), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .busy(busy), .frame_done(frame_done));
  spi_fifo_tx_ctrl #(.DATA_W(DATA_W), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .GAP(1)) dut_f (
    .HCLK(HCLK), .HRESETn(HRESETn), .enable(en_f), .fifo_empty(empty_f), .fifo_rd_en(rd_f),
    .fifo_rd_data(rd_data_f), .spi_cs_n(cs_f), .spi_sclk(sclk_f), .spi_mosi(mosi_f),
    .busy(busy_f), .frame_done(done_f));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_drain(input int budget);
    int i = 0;
    while (!(fifo_q.size() == 0 && exp_q.size() == 0 && !busy && spi_cs_n && !fifo_rd_en) && i < budget) begin
      @(negedge HCLK);
      i++;
    end
    chk("drain_in_budget", 32'(i < budget), 1);
  endtask
  task automatic wait_bits(input int n, input int budget);
    int i = 0;
    while (nbits < n && i < budget) begin
      @(negedge HCLK);
      i++;
    end
    chk("bits_in_budget", 32'(i < budget), 1);
  endtask
  task automatic wait_frames(input int n, input int budget);
    int i = 0;
    while (frames < n && i < budget) begin
      @(negedge HCLK);
      i++;
    end
    chk("frames_in_budget", 32'(i < budget), 1);
  endtask
  initial begin
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        exp_q.delete();
        nbits = 0; low = 0; high = 0; seen = 0;
        prev_cs = 1; prev_sclk = 0; prev_rd = 0;
      end else begin
        if (fifo_rd_en) begin
          chk("pop_nonempty", 32'(fifo_q.size() != 0), 1);
          if (fifo_q.size() != 0) begin
            fifo_rd_data = fifo_q.pop_front();
            exp_q.push_back(fifo_rd_data);
          end
          rd_cnt++;
        end
        chk("rd_pulse_width", 32'(fifo_rd_en && prev_rd), 0);
        if (spi_sclk && !prev_sclk) begin
          chk("rise_in_frame", 32'(spi_cs_n), 0);
          word = {word[DATA_W-2:0], spi_mosi};
          nbits++;
        end
        if (spi_cs_n && !prev_cs) begin
          chk("frame_bits", nbits, DATA_W);
          chk("cs_low_time", low, LOW_T);
          chk("frame_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) chk("frame_data", 32'(word), 32'(exp_q.pop_front()));
          last_word = word;
          frames++;
          nbits = 0; low = 0; high = 0; seen = 1;
        end
        if (!spi_cs_n && prev_cs && seen) chk("cs_gap", 32'(high >= GAP + 2), 1);
        chk("done_at_cs_rise", 32'(frame_done), 32'(spi_cs_n && !prev_cs));
        if (spi_cs_n) begin
          chk("sclk_idle", 32'(spi_sclk), 0);
          chk("mosi_idle", 32'(spi_mosi), 0);
          high++;
        end else begin
          chk("busy_in_frame", 32'(busy), 1);
          low++;
        end
        prev_cs = spi_cs_n; prev_sclk = spi_sclk; prev_rd = fifo_rd_en;
      end
      fifo_empty = fifo_q.size() == 0;
    end
  end
  initial begin
    forever begin
      @(negedge HCLK);
      cyc++;
      if (!HRESETn) begin
        nb_f = 0; low_f = 0; prev_cs_f = 1; prev_sclk_f = 0;
      end else begin
        if (rd_f) begin
          rd_cnt_f++;
          rd_data_f = 24'h5A5A5A;
        end
        if (sclk_f && !prev_sclk_f) begin
          if (nb_f > 0) chk("fast_sclk_period", cyc - last_rise, 2);
          last_rise = cyc;
          word_f = {word_f[DATA_W-2:0], mosi_f};
          nb_f++;
        end
        if (cs_f && !prev_cs_f) begin
          chk("fast_bits", nb_f, DATA_W);
          chk("fast_cs_low", low_f, LOW_F);
          chk("fast_data", 32'(word_f), 32'h5A5A5A);
          chk("fast_done", 32'(done_f), 1);
          frames_f++;
          nb_f = 0; low_f = 0;
        end
        if (!cs_f) low_f++;
        prev_cs_f = cs_f; prev_sclk_f = sclk_f;
      end
      empty_f = !(go_f && rd_cnt_f == 0);
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [DATA_W-1:0] w0, w1, w2, w3;
    int n, exp_frames;
    repeat (3) @(negedge HCLK);
    chk("rst_cs_n", 32'(spi_cs_n), 1);
    chk("rst_sclk", 32'(spi_sclk), 0);
    chk("rst_mosi", 32'(spi_mosi), 0);
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_fast_cs_n", 32'(cs_f), 1);
    HRESETn = 1;
    enable = 1;
    repeat (40) @(negedge HCLK);
    chk("empty_no_pop", rd_cnt, 0);
    chk("empty_cs_n", 32'(spi_cs_n), 1);
    chk("empty_busy", 32'(busy), 0);
    fifo_q.push_back(24'hA5C30F);
    wait_drain(400);
    chk("single_frames", frames, 1);
    chk("single_pops", rd_cnt, 1);
    chk("single_word", 32'(last_word), 32'hA5C30F);
    fifo_q.push_back(24'h000001);
    fifo_q.push_back(24'h800000);
    fifo_q.push_back(24'hFFFFFF);
    wait_drain(1200);
    chk("three_frames", frames, 4);
    chk("three_pops", rd_cnt, 4);
    chk("three_last", 32'(last_word), 32'hFFFFFF);
    w0 = 24'($urandom());
    w1 = 24'($urandom());
    fifo_q.push_back(w0);
    fifo_q.push_back(w1);
    wait_bits(10, 300);
    enable = 0;
    wait_frames(5, 400);
    repeat (40) @(negedge HCLK);
    chk("disable_pops", rd_cnt, 5);
    chk("disable_left", fifo_q.size(), 1);
    chk("disable_busy", 32'(busy), 0);
    chk("disable_word", 32'(last_word), 32'(w0));
    enable = 1;
    wait_drain(600);
    chk("reenable_frames", frames, 6);
    chk("reenable_word", 32'(last_word), 32'(w1));
    w2 = 24'($urandom());
    w3 = 24'($urandom());
    fifo_q.push_back(w2);
    fifo_q.push_back(w3);
    wait_bits(12, 300);
    @(negedge HCLK);
    #2 HRESETn = 0;
    #1;
    chk("async_cs_n", 32'(spi_cs_n), 1);
    chk("async_sclk", 32'(spi_sclk), 0);
    chk("async_mosi", 32'(spi_mosi), 0);
    chk("async_busy", 32'(busy), 0);
    repeat (3) @(negedge HCLK);
    HRESETn = 1;
    wait_drain(600);
    chk("post_reset_frames", frames, 7);
    chk("post_reset_word", 32'(last_word), 32'(w3));
    exp_frames = 7;
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) fifo_q.push_back(24'($urandom()));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(5, 300)) @(negedge HCLK);
        enable = 0;
        repeat ($urandom_range(1, 50)) @(negedge HCLK);
        enable = 1;
      end
      wait_drain(2000);
      exp_frames += n;
      chk("random_frames", frames, exp_frames);
      chk("random_pops", rd_cnt, exp_frames + 1);
    end
    go_f = 1;
    en_f = 1;
    for (int i = 0; i < 200 && frames_f == 0; i++) @(negedge HCLK);
    repeat (5) @(negedge HCLK);
    chk("fast_frames", frames_f, 1);
    chk("fast_pops", rd_cnt_f, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
